// File: rtl/uart_rx_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cfg_pkg
// Brief   : Shared parity-mode codes, FSM state encoding and helpers for the
//           configurable UART receiver.
// Revision: 1.0 - initial release
// ============================================================================
package uart_rx_cfg_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } state_t;

    // Codes 5..7 have no meaning on the line and behave as "no parity".
    function automatic logic [2:0] norm_parity(input logic [2:0] mode);
        return (mode > PAR_SPACE) ? PAR_NONE : mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cfg_if
// Brief   : AXI-stream character channel from the UART receiver to its sink.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cfg_bit_sampler
// Brief   : rxd synchroniser, falling-edge detect, per-bit timing counter and
//           3-sample majority vote with sample/bit-end strobes.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_cfg_bit_sampler #(
    parameter int PRESCALE_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  rxd,
    input  wire logic                  active,
    input  wire logic                  restart,
    input  wire logic [PRESCALE_W-1:0] prescale,
    output logic                       rxd_s,
    output logic                       fall,
    output logic                       mid,
    output logic                       bit_valid,
    output logic                       bit_end,
    output logic                       bit_val
);
    localparam int CW = PRESCALE_W + 3;

    logic          sync1;
    logic          sync2;
    logic          rxd_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] p3;
    logic [CW-1:0] p4;
    logic [CW-1:0] p5;
    logic [CW-1:0] last;
    logic          samp3;
    logic          samp4;

    assign p3   = {3'b000, prescale} + {2'b00, prescale, 1'b0};
    assign p4   = {1'b0, prescale, 2'b00};
    assign p5   = p4 + {3'b000, prescale};
    assign last = {prescale, 3'b000} - CW'(1);

    // Two-stage synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            rxd_d <= sync2;
        end
    end

    // The start-detect cycle is position 0, so a restart loads position 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CW'(1);
        end else if (active) begin
            cnt <= (cnt == last) ? '0 : cnt + CW'(1);
        end
    end

    // Hold the first two votes; the third is the live line at prescale*5.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp3 <= 1'b0;
            samp4 <= 1'b0;
        end else if (active) begin
            if (cnt == p3) samp3 <= sync2;
            if (cnt == p4) samp4 <= sync2;
        end
    end

    assign rxd_s     = sync2;
    assign fall      = rxd_d & ~sync2;
    assign mid       = active && (cnt == p4);
    assign bit_valid = active && (cnt == p5);
    assign bit_end   = active && (cnt == last);
    assign bit_val   = (samp3 & samp4) | (samp3 & sync2) | (samp4 & sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cfg
// Brief   : Runtime-configurable UART receiver (5..DATA_WIDTH bits, parity,
//           1/2 stop bits) with glitch rejection, majority sampling, parity,
//           frame, overrun and break reporting onto an AXI-stream channel.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    uart_rx_cfg_if.master              output_axis,
    input  wire logic                  rxd,
    output logic                       busy,
    output logic                       overrun_error,
    output logic                       frame_error,
    output logic                       break_detect,
    input  wire logic [PRESCALE_W-1:0] prescale,
    input  wire logic [3:0]            cfg_data_bits,
    input  wire logic [2:0]            cfg_parity,
    input  wire logic                  cfg_stop2
);
    import uart_rx_cfg_pkg::*;

    localparam logic [3:0] DW4 = 4'(DATA_WIDTH);

    state_t                  state;
    state_t                  next_state;

    logic [PRESCALE_W-1:0]   lat_prescale;
    logic [3:0]              lat_bits;
    logic [2:0]              lat_parity;
    logic                    lat_stop2;
    logic [3:0]              eff_bits;

    logic                    start_ok;
    logic                    second_stop;
    logic                    perr;
    logic                    any_one;
    logic                    par_bit;
    logic                    par_acc;
    logic                    exp_par;
    logic [3:0]              bit_idx;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   rx_char;

    logic                    rxd_s;
    logic                    fall;
    logic                    mid;
    logic                    bit_valid;
    logic                    bit_end;
    logic                    bit_val;
    logic                    active;

    logic                    start_det;
    logic                    char_ok;
    logic                    frame_flt;
    logic                    brk_flt;

    logic [DATA_WIDTH-1:0]   axis_tdata;
    logic                    axis_tuser;
    logic                    axis_tvalid;

    assign eff_bits = (cfg_data_bits < 4'd5 || cfg_data_bits > DW4) ? DW4 : cfg_data_bits;
    assign active   = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);

    uart_rx_cfg_bit_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .active    (active),
        .restart   (start_det),
        .prescale  (lat_prescale),
        .rxd_s     (rxd_s),
        .fall      (fall),
        .mid       (mid),
        .bit_valid (bit_valid),
        .bit_end   (bit_end),
        .bit_val   (bit_val)
    );

    // Expected parity bit for the latched mode given the accumulated data XOR.
    always_comb begin
        exp_par = 1'b0;
        case (lat_parity)
            PAR_EVEN: exp_par = par_acc;
            PAR_ODD:  exp_par = ~par_acc;
            PAR_MARK: exp_par = 1'b1;
            default:  exp_par = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state and one-cycle event strobes for the datapath.
    always_comb begin
        next_state = state;
        start_det  = 1'b0;
        char_ok    = 1'b0;
        frame_flt  = 1'b0;
        brk_flt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (prescale != '0 && fall) begin
                    next_state = ST_START;
                    start_det  = 1'b1;
                end
            end
            ST_START: begin
                if (mid && rxd_s)  next_state = ST_IDLE;
                else if (bit_end)  next_state = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == lat_bits - 4'd1)
                    next_state = (lat_parity == PAR_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                if (bit_end) next_state = ST_STOP;
            end
            ST_STOP: begin
                // Decide at the third vote so a back-to-back start is not missed.
                if (bit_valid) begin
                    if (!bit_val) begin
                        if (!any_one && !par_bit) begin
                            brk_flt    = 1'b1;
                            next_state = ST_BRK;
                        end else begin
                            frame_flt  = 1'b1;
                            next_state = ST_IDLE;
                        end
                    end else if (!lat_stop2 || second_stop) begin
                        char_ok    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_BRK: begin
                if (rxd_s) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Per-character configuration snapshot, shift register and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_prescale <= '0;
            lat_bits     <= DW4;
            lat_parity   <= PAR_NONE;
            lat_stop2    <= 1'b0;
            start_ok     <= 1'b0;
            second_stop  <= 1'b0;
            perr         <= 1'b0;
            any_one      <= 1'b0;
            par_bit      <= 1'b0;
            par_acc      <= 1'b0;
            bit_idx      <= '0;
            shift_reg    <= '0;
        end else begin
            if (start_det) begin
                lat_prescale <= prescale;
                lat_bits     <= eff_bits;
                lat_parity   <= norm_parity(cfg_parity);
                lat_stop2    <= cfg_stop2;
                start_ok     <= 1'b0;
                second_stop  <= 1'b0;
                perr         <= 1'b0;
                any_one      <= 1'b0;
                par_bit      <= 1'b0;
                par_acc      <= 1'b0;
                bit_idx      <= '0;
            end
            if (state == ST_START && mid && !rxd_s) start_ok <= 1'b1;
            if (state == ST_DATA) begin
                if (bit_valid) begin
                    shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                    par_acc   <= par_acc ^ bit_val;
                    any_one   <= any_one | bit_val;
                end
                if (bit_end) bit_idx <= bit_idx + 4'd1;
            end
            if (state == ST_PARITY && bit_valid) begin
                par_bit <= bit_val;
                perr    <= (bit_val != exp_par);
            end
            if (state == ST_STOP && bit_end) second_stop <= 1'b1;
        end
    end

    // Characters enter at the MSB end; shift down to right-justify.
    assign rx_char = shift_reg >> (DW4 - lat_bits);

    // Output register and status pulses; a delivery beats a same-cycle accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            axis_tdata    <= '0;
            axis_tuser    <= 1'b0;
            axis_tvalid   <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= frame_flt;
            break_detect  <= brk_flt;
            if (char_ok && !(axis_tvalid && !output_axis.tready)) begin
                axis_tdata  <= rx_char;
                axis_tuser  <= perr;
                axis_tvalid <= 1'b1;
            end else begin
                if (char_ok) overrun_error <= 1'b1;
                if (axis_tvalid && output_axis.tready) axis_tvalid <= 1'b0;
            end
        end
    end

    assign output_axis.tdata  = axis_tdata;
    assign output_axis.tuser  = axis_tuser;
    assign output_axis.tvalid = axis_tvalid;

    assign busy = ((state == ST_START) && start_ok) || (state == ST_DATA) ||
                  (state == ST_PARITY) || (state == ST_STOP) || (state == ST_BRK);

endmodule
`default_nettype wire
